// File: rtl/shift_p_decoder16.sv
// Grant side of the 16-entry rotating-priority select path: pending mask, rotation base and 2-deep grant FIFO.
// Optional macro SHIFT_P_DEC_STALL_CNT_EN adds a saturating stall_cnt output.
module shift_p_decoder16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:15] req_set,
  output logic [0:15] pending,
  output logic [3:0]  shift_base,
  input  logic [3:0]  sel_idx,
  input  logic        sel_valid,
  output logic        sel_ready,
  output logic [0:15] grant_onehot,
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  input  logic        grant_ready,
`ifdef SHIFT_P_DEC_STALL_CNT_EN
  output logic [7:0]  stall_cnt,
`endif
  output logic        err_stale
);

  logic [1:0]  count;
  logic [0:15] head_oh, tail_oh;
  logic [3:0]  head_idx, tail_idx;
  logic [0:15] sel_oh;
  logic [0:15] clr;
  logic        accept, pop;

  always_comb begin
    sel_oh = '0;
    sel_oh[sel_idx] = 1'b1;
  end

  assign sel_ready   = (count != 2'd2);
  assign grant_valid = (count != 2'd0);
  assign accept      = sel_valid & sel_ready;
  assign pop         = grant_valid & grant_ready;
  assign clr         = accept ? sel_oh : '0;

  // Head is gated so an empty FIFO always presents zeros.
  assign grant_onehot = grant_valid ? head_oh  : '0;
  assign grant_idx    = grant_valid ? head_idx : 4'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      shift_base <= 4'd0;
      err_stale  <= 1'b0;
      count      <= 2'd0;
      head_oh    <= '0;
      head_idx   <= 4'd0;
      tail_oh    <= '0;
      tail_idx   <= 4'd0;
    end else begin
      // Set wins over clear when both hit the same bit.
      pending <= (pending & ~clr) | req_set;
      if (accept) begin
        shift_base <= sel_idx + 4'd1;
        if (!pending[sel_idx])
          err_stale <= 1'b1;
      end
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_oh  <= sel_oh;
            head_idx <= sel_idx;
          end else begin
            tail_oh  <= sel_oh;
            tail_idx <= sel_idx;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_oh  <= tail_oh;
          head_idx <= tail_idx;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_oh  <= sel_oh;
            head_idx <= sel_idx;
          end else begin
            head_oh  <= tail_oh;
            head_idx <= tail_idx;
            tail_oh  <= sel_oh;
            tail_idx <= sel_idx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_P_DEC_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= 8'd0;
    else if (grant_valid && !grant_ready && stall_cnt != 8'hFF)
      stall_cnt <= stall_cnt + 8'd1;
  end
`endif

endmodule
